// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port (cpu/dbg) data-memory arbiter with anti-starvation
//               priority for the debug port and fully registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [15:0] dbg_rdata,
    output logic [15:0] DMem_addr,
    output logic [15:0] DMem_din,
    output logic        DMem_rd,
    input  logic [15:0] memout,
    output logic        busy
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_ACC        = 2'd1;
    localparam logic [1:0] c_RWAIT      = 2'd2;
    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_MAX);
    localparam logic [2:0] c_READ_LAT   = 3'(READ_LAT);

    logic [1:0]  r_state;
    logic        r_ready;
    logic [7:0]  r_starve_cnt;
    logic        r_owner_dbg;
    logic        r_we;
    logic [2:0]  r_cnt;
    logic        r_cpu_gnt;
    logic        r_dbg_gnt;
    logic        r_cpu_rvalid;
    logic        r_dbg_rvalid;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_dbg_rdata;
    logic [15:0] r_dmem_addr;
    logic [15:0] r_dmem_din;
    logic        r_dmem_rd;
    logic        r_busy;

    logic        w_idle;
    logic        w_starved;
    logic        w_cpu_win;
    logic        w_dbg_win;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [15:0] w_sel_wdata;

    // r_ready holds off arbitration for the first edge after reset release.
    assign w_idle      = r_ready && (r_state == c_IDLE);
    assign w_starved   = (r_starve_cnt >= c_STARVE_MAX);
    assign w_cpu_win   = w_idle && cpu_req && !(dbg_req && w_starved);
    assign w_dbg_win   = w_idle && dbg_req && (!cpu_req || w_starved);
    assign w_sel_we    = w_dbg_win ? dbg_we    : cpu_we;
    assign w_sel_addr  = w_dbg_win ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = w_dbg_win ? dbg_wdata : cpu_wdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_ready      <= 1'b0;
            r_starve_cnt <= 8'd0;
            r_owner_dbg  <= 1'b0;
            r_we         <= 1'b0;
            r_cnt        <= 3'd0;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= 16'd0;
            r_dbg_rdata  <= 16'd0;
            r_dmem_addr  <= 16'd0;
            r_dmem_din   <= 16'd0;
            r_dmem_rd    <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_ready      <= 1'b1;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;

            if (!dbg_req || w_dbg_win) begin
                r_starve_cnt <= 8'd0;
            end else if (r_starve_cnt < c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_cpu_win || w_dbg_win) begin
                        r_state     <= c_ACC;
                        r_owner_dbg <= w_dbg_win;
                        r_we        <= w_sel_we;
                        r_cpu_gnt   <= w_cpu_win;
                        r_dbg_gnt   <= w_dbg_win;
                        r_busy      <= 1'b1;
                        r_dmem_addr <= w_sel_addr;
                        if (w_sel_we) begin
                            r_dmem_rd  <= 1'b0;
                            r_dmem_din <= w_sel_wdata;
                        end
                    end
                end
                c_ACC: begin
                    if (r_we) begin
                        r_state    <= c_IDLE;
                        r_busy     <= 1'b0;
                        r_dmem_rd  <= 1'b1;
                        r_dmem_din <= 16'd0;
                    end else begin
                        r_state <= c_RWAIT;
                        r_cnt   <= 3'd1;
                    end
                end
                c_RWAIT: begin
                    if (r_cnt == c_READ_LAT) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                        if (r_owner_dbg) begin
                            r_dbg_rdata  <= memout;
                            r_dbg_rvalid <= 1'b1;
                        end else begin
                            r_cpu_rdata  <= memout;
                            r_cpu_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_busy     <= 1'b0;
                    r_dmem_rd  <= 1'b1;
                    r_dmem_din <= 16'd0;
                end
            endcase
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign dbg_gnt    = r_dbg_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dbg_rdata  = r_dbg_rdata;
    assign DMem_addr  = r_dmem_addr;
    assign DMem_din   = r_dmem_din;
    assign DMem_rd    = r_dmem_rd;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter
//               (READ_LAT=2, STARVE_MAX=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, memout;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, DMem_rd, busy;
    logic [15:0] cpu_rdata, dbg_rdata, DMem_addr, DMem_din;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.READ_LAT(2), .STARVE_MAX(3)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .DMem_addr(DMem_addr), .DMem_din(DMem_din), .DMem_rd(DMem_rd),
        .memout(memout), .busy(busy)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle_inputs(); memout = 16'h0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h00AA;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %0b%0b exp 00", cpu_gnt, dbg_gnt); end
        checks++; if (DMem_rd !== 1'b1 || DMem_addr !== 16'h0 || DMem_din !== 16'h0) begin errors++; $display("FAIL rst_mem got rd=%0b addr=%h din=%h exp 1/0000/0000", DMem_rd, DMem_addr, DMem_din); end
        checks++; if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0 || cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rdata got %h %h exp 0000 0000", cpu_rdata, dbg_rdata); end
        checks++; if (dut.r_starve_cnt !== 8'd0) begin errors++; $display("FAIL rst_starve got %0d exp 0", dut.r_starve_cnt); end
        reset = 1;
        tick();
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_first_edge_gnt got %0b exp 0", cpu_gnt); end
        tick();
        checks++; if (cpu_gnt !== 1'b1 || DMem_rd !== 1'b0 || DMem_din !== 16'h00AA) begin errors++; $display("FAIL rst_second_edge_gnt got gnt=%0b rd=%0b din=%h exp 1/0/00aa", cpu_gnt, DMem_rd, DMem_din); end
        idle_inputs();
        tick();
        checks++; if (busy !== 1'b0 || DMem_rd !== 1'b1) begin errors++; $display("FAIL rst_wr_done got busy=%0b rd=%0b exp 0/1", busy, DMem_rd); end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        tick();
        checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || DMem_addr !== 16'h3000 || busy !== 1'b1) begin errors++; $display("FAIL rd_c1 got gnt=%0b addr=%h busy=%0b exp 1/3000/1", cpu_gnt, DMem_addr, busy); end
        idle_inputs();
        tick();
        checks++; if (cpu_gnt !== 1'b0 || DMem_addr !== 16'h3000 || DMem_rd !== 1'b1) begin errors++; $display("FAIL rd_c2 got gnt=%0b addr=%h rd=%0b exp 0/3000/1", cpu_gnt, DMem_addr, DMem_rd); end
        tick();
        memout = 16'hBEEF;
        checks++; if (DMem_addr !== 16'h3000 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_c3 got addr=%h rvalid=%0b exp 3000/0", DMem_addr, cpu_rvalid); end
        tick();
        memout = 16'h0;
        checks++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF || busy !== 1'b0) begin errors++; $display("FAIL rd_c4 got rvalid=%0b rdata=%h busy=%0b exp 1/beef/0", cpu_rvalid, cpu_rdata, busy); end
        tick();
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_hold got rvalid=%0b rdata=%h exp 0/beef", cpu_rvalid, cpu_rdata); end
    endtask

    task automatic test_dbg_write();
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h4000; dbg_wdata = 16'h1234;
        tick();
        checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || DMem_rd !== 1'b0 || DMem_addr !== 16'h4000 || DMem_din !== 16'h1234) begin errors++; $display("FAIL wr_acc got gnt=%0b rd=%0b addr=%h din=%h exp 1/0/4000/1234", dbg_gnt, DMem_rd, DMem_addr, DMem_din); end
        idle_inputs();
        tick();
        checks++; if (busy !== 1'b0 || DMem_rd !== 1'b1 || DMem_din !== 16'h0 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL wr_done got busy=%0b rd=%0b din=%h gnt=%0b exp 0/1/0000/0", busy, DMem_rd, DMem_din, dbg_gnt); end
    endtask

    task automatic test_starvation();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h5000; cpu_wdata = 16'h1111;
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h6000; dbg_wdata = 16'h2222;
        tick();
        checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL stv_c1 got cpu=%0b dbg=%0b exp 1/0", cpu_gnt, dbg_gnt); end
        tick(); tick();
        checks++; if (cpu_gnt !== 1'b1 || dut.r_starve_cnt !== 8'd3) begin errors++; $display("FAIL stv_c3 got cpu=%0b starve=%0d exp 1/3", cpu_gnt, dut.r_starve_cnt); end
        tick(); tick();
        checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || DMem_addr !== 16'h6000 || DMem_din !== 16'h2222 || dut.r_starve_cnt !== 8'd0) begin errors++; $display("FAIL stv_dbg got dbg=%0b cpu=%0b addr=%h din=%h starve=%0d exp 1/0/6000/2222/0", dbg_gnt, cpu_gnt, DMem_addr, DMem_din, dut.r_starve_cnt); end
        tick(); tick();
        checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || DMem_addr !== 16'h5000) begin errors++; $display("FAIL stv_cpu_next got cpu=%0b dbg=%0b addr=%h exp 1/0/5000", cpu_gnt, dbg_gnt, DMem_addr); end
        idle_inputs();
        tick();
    endtask

    task automatic test_simultaneous();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h7000;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h7100;
        tick();
        checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || DMem_addr !== 16'h7000) begin errors++; $display("FAIL sim_gnt got cpu=%0b dbg=%0b addr=%h exp 1/0/7000", cpu_gnt, dbg_gnt, DMem_addr); end
        idle_inputs();
        tick(); tick();
        memout = 16'h5555;
        tick();
        memout = 16'h0;
        checks++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== 16'h5555 || dbg_rdata !== 16'h0) begin errors++; $display("FAIL sim_rvalid got cpu=%0b dbg=%0b crd=%h drd=%h exp 1/0/5555/0000", cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        tick();
        idle_inputs();
        tick(); tick();
        memout = 16'h0A0A;
        tick();
        memout = 16'h0;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h0A0A) begin errors++; $display("FAIL b2b_first got rvalid=%0b rdata=%h exp 1/0a0a", cpu_rvalid, cpu_rdata); end
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3001;
        tick();
        checks++; if (cpu_gnt !== 1'b1 || DMem_addr !== 16'h3001 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_gnt got gnt=%0b addr=%h rvalid=%0b exp 1/3001/0", cpu_gnt, DMem_addr, cpu_rvalid); end
        idle_inputs();
        tick(); tick();
        memout = 16'hC0DE;
        tick();
        memout = 16'h0;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hC0DE) begin errors++; $display("FAIL b2b_second got rvalid=%0b rdata=%h exp 1/c0de", cpu_rvalid, cpu_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8000;
        tick();
        idle_inputs();
        tick();
        reset = 0;
        memout = 16'hDEAD;
        tick();
        checks++; if (busy !== 1'b0 || DMem_rd !== 1'b1 || DMem_addr !== 16'h0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0) begin errors++; $display("FAIL mrst_state got busy=%0b rd=%0b addr=%h rvalid=%0b rdata=%h exp 0/1/0000/0/0000", busy, DMem_rd, DMem_addr, cpu_rvalid, cpu_rdata); end
        reset = 1;
        tick();
        checks++; if (cpu_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_after got rvalid=%0b busy=%0b exp 0/0", cpu_rvalid, busy); end
        tick();
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL mrst_no_rvalid got %0b exp 0", cpu_rvalid); end
        memout = 16'h0;
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && cpu_gnt === 1'b1 && dbg_gnt === 1'b1) begin
            errors++; $display("FAIL gnt_exclusive got 11 exp not both");
        end
        if (reset === 1'b1 && cpu_rvalid === 1'b1 && dbg_rvalid === 1'b1) begin
            errors++; $display("FAIL rvalid_exclusive got 11 exp not both");
        end
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_starvation();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
